tmds_word_encoder: RTL and testbench
====================================

Name: tmds_word_encoder

Overview:
- Encodes one RGB888 pixel per pixel-clock cycle, plus HSYNC/VSYNC/DE, into three 10-bit TMDS symbols per DVI 1.0 (8b/10b TMDS with DC balancing).
- Also emits a constant 10-bit clock-channel word.
- Sits between the video timing/pattern generator and the 10:1 serializer/LVDS output stage. Serialization, the x5 clock and the PLLs are outside this block.

Parameters:
- CTL_WORD_00, 10'b1101010100, control token for {C1,C0}=00
- CTL_WORD_01, 10'b0010101011, control token for {C1,C0}=01
- CTL_WORD_10, 10'b0101010100, control token for {C1,C0}=10
- CTL_WORD_11, 10'b1010101011, control token for {C1,C0}=11
- CLK_WORD, 10'b1111100000, clock-channel pattern

Ports:
- pclk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous active-low reset
- video_din  in  24  RGB888: [23:16] red, [15:8] green, [7:0] blue
- video_hsync  in  1  horizontal sync, active level passed through unchanged
- video_vsync  in  1  vertical sync
- video_de  in  1  data enable (active video)
- tmds_ch0  out  10  blue symbol; bit0 is serialized first
- tmds_ch1  out  10  green symbol
- tmds_ch2  out  10  red symbol
- tmds_clk_word  out  10  clock-channel word

Behaviour:
- One clock (pclk); reset_n is asynchronous active-low. All state is clocked on the rising edge of pclk.
- Reset values:
  - tmds_ch0/1/2 = CTL_WORD_00
  - tmds_clk_word = CLK_WORD
  - all disparity counters = 0
  - pipeline registers = 0, with DE = 0
- Latency: exactly 2 pclk cycles from inputs to outputs.
  - Stage 1 registers the inputs and computes q_m.
  - Stage 2 computes the final symbol and updates the disparity counter.
  - DE, C0 and C1 are delayed alongside the data.
- Control mapping:
  - ch0: C0 = hsync, C1 = vsync
  - ch1 and ch2: C0 = C1 = 0
- DE = 0 (blanking):
  - output = token selected by {C1,C0}
  - channel disparity counter forced to 0
- DE = 1, stage 1 (per channel, D = 8-bit component, N1/N0 = count of ones/zeros):
  - If N1(D) > 4, or N1(D) == 4 and D[0] == 0 (XNOR path): q_m[0] = D[0]; q_m[i] = q_m[i-1] XNOR D[i]; q_m[8] = 0.
  - Otherwise (XOR path): q_m[i] = q_m[i-1] XOR D[i]; q_m[8] = 1.
- DE = 1, stage 2 (cnt is a signed 5-bit counter, N1/N0 taken over q_m[7:0]):
  - Case A, cnt == 0 or N1 == N0:
    - out[9] = ~q_m[8]; out[8] = q_m[8]
    - out[7:0] = q_m[8] ? q_m[7:0] : ~q_m[7:0]
    - cnt += q_m[8] ? (N1 - N0) : (N0 - N1)
  - Case B, (cnt > 0 and N1 > N0) or (cnt < 0 and N0 > N1):
    - out = {1, q_m[8], ~q_m[7:0]}
    - cnt += 2*q_m[8] + (N0 - N1)
  - Case C, otherwise:
    - out = {0, q_m[8], q_m[7:0]}
    - cnt += (N1 - N0) - 2*(~q_m[8])
- cnt range: always within [-16, 15]; wrap-around never occurs for legal sequences. Arithmetic is signed and sign-extended to 5 bits.
- tmds_clk_word is held constant at CLK_WORD at all times.
- Reset asserted mid-line: outputs return to CTL_WORD_00 immediately (asynchronous). After release, the first valid symbol appears 2 cycles after the first sampled input.
- A DE edge inside the pipeline takes effect exactly 2 cycles later. The counter restarts at 0 for each new active line.

Decomposition:
- Shared package holds:
  - the four control tokens and CLK_WORD
  - TMDS symbol width (10)
  - a popcount function for 8 bits
- One sub-module, tmds_channel_encoder: 8-bit data, C0, C1, DE in; 10-bit symbol out; owns the 2-stage pipeline and its cnt. It is instantiated three times.
- The top level only maps channels and drives tmds_clk_word.

Test Plan:
- Reset held low → all channels 1101010100, tmds_clk_word 1111100000; release with DE = 0, hsync = vsync = 0 → outputs unchanged.
- DE = 0, hsync = 1, vsync = 0 → ch0 = 0010101011 after 2 cycles; ch1/ch2 = 1101010100. Cover all four {vsync,hsync} combinations on ch0.
- DE rises, blue = 0x00 for two cycles, starting from cnt = 0:
  - 1st symbol 0100000000 (cnt → -8)
  - 2nd symbol 1111111111 (cnt → +2)
  - first data symbol appears 2 cycles after DE rises
- DE = 1, green = 0xFF from cnt = 0 → ch1 = 1000000000 (cnt → -8).
- Random 1920-pixel lines with DE framing, checked against a reference model:
  - every symbol matches the model
  - running disparity stays within ±10
  - cnt returns to 0 during blanking
- Assert reset_n mid-line → outputs become 1101010100 asynchronously; the next line encodes with cnt starting at 0.

Source files
------------

// File: rtl/tmds_word_encoder_pkg.sv
// Shared definitions for the TMDS word encoder.
//   - SYM_W       : width of one TMDS symbol (10 bits)
//   - CTL_WORD_xx : control tokens sent during blanking, indexed by {C1,C0}
//   - CLK_WORD    : fixed pattern for the clock channel
//   - popcount8() : number of ones in an 8-bit value
package tmds_word_encoder_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] CTL_WORD_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTL_WORD_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTL_WORD_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTL_WORD_11 = 10'b1010101011;
  localparam logic [SYM_W-1:0] CLK_WORD    = 10'b1111100000;

  function automatic logic [3:0] popcount8(input logic [7:0] value);
    logic [3:0] count;
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, value[i]};
    end
    return count;
  endfunction

endpackage

// File: rtl/tmds_word_encoder_channel.sv
// One TMDS channel: 8b/10b transition-minimising encode with DC balancing.
// Two-stage pipeline, so a symbol appears two pclk edges after its inputs
// are sampled.
//   pclk    : pixel clock
//   reset_n : asynchronous active-low reset
//   data    : 8-bit colour component
//   c0, c1  : control bits, selecting the blanking token
//   de      : data enable, 1 = active video
//   symbol  : 10-bit TMDS symbol, bit 0 serialized first
module tmds_channel_encoder
  import tmds_word_encoder_pkg::*;
(
  input  logic             pclk,
  input  logic             reset_n,
  input  logic [7:0]       data,
  input  logic             c0,
  input  logic             c1,
  input  logic             de,
  output logic [SYM_W-1:0] symbol
);

  logic [8:0]        q_m_next;
  logic [8:0]        q_m_s1;
  logic              de_s1;
  logic [1:0]        ctl_s1;
  logic [3:0]        n1_q;
  logic signed [5:0] bias_wide;
  logic signed [4:0] bias;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_next;
  logic [SYM_W-1:0]  symbol_next;

  // Transition-minimised 9-bit word: bit 8 records which chaining
  // operator was used so the receiver can undo it.
  function automatic logic [8:0] encode_qm(input logic [7:0] d);
    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] q;
    ones     = popcount8(d);
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  always_comb begin
    q_m_next = encode_qm(data);
  end

  // Stage 1: hold q_m together with the matching DE and control bits.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      q_m_s1 <= '0;
      de_s1  <= 1'b0;
      ctl_s1 <= 2'b00;
    end else begin
      q_m_s1 <= q_m_next;
      de_s1  <= de;
      ctl_s1 <= {c1, c0};
    end
  end

  // Stage 2: choose whether to invert q_m[7:0] so the running disparity
  // (cnt, ones minus zeros sent so far) is pulled back toward zero.
  // bias = N1 - N0 of q_m[7:0] = 2*N1 - 8, always in [-8, 8].
  always_comb begin
    n1_q        = popcount8(q_m_s1[7:0]);
    bias_wide   = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
    bias        = bias_wide[4:0];
    symbol_next = CTL_WORD_00;
    cnt_next    = 5'sd0;
    if (!de_s1) begin
      case (ctl_s1)
        2'b00:   symbol_next = CTL_WORD_00;
        2'b01:   symbol_next = CTL_WORD_01;
        2'b10:   symbol_next = CTL_WORD_10;
        default: symbol_next = CTL_WORD_11;
      endcase
    end else if ((cnt == 5'sd0) || (bias == 5'sd0)) begin
      symbol_next = {~q_m_s1[8], q_m_s1[8],
                     q_m_s1[8] ? q_m_s1[7:0] : ~q_m_s1[7:0]};
      cnt_next    = q_m_s1[8] ? (cnt + bias) : (cnt - bias);
    end else if (((cnt > 5'sd0) && (bias > 5'sd0)) ||
                 ((cnt < 5'sd0) && (bias < 5'sd0))) begin
      symbol_next = {1'b1, q_m_s1[8], ~q_m_s1[7:0]};
      cnt_next    = cnt - bias + (q_m_s1[8] ? 5'sd2 : 5'sd0);
    end else begin
      symbol_next = {1'b0, q_m_s1[8], q_m_s1[7:0]};
      cnt_next    = cnt + bias - (q_m_s1[8] ? 5'sd0 : 5'sd2);
    end
  end

  // Blanking forces cnt to zero, so every active line starts balanced.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      symbol <= CTL_WORD_00;
      cnt    <= 5'sd0;
    end else begin
      symbol <= symbol_next;
      cnt    <= cnt_next;
    end
  end

endmodule

// File: rtl/tmds_word_encoder.sv
// DVI TMDS word encoder: one RGB888 pixel plus syncs per pclk in, three
// 10-bit channel symbols plus the clock-channel word out (latency 2).
//   pclk          : pixel clock
//   reset_n       : asynchronous active-low reset
//   video_din     : [23:16] red, [15:8] green, [7:0] blue
//   video_hsync   : horizontal sync, carried as C0 on channel 0
//   video_vsync   : vertical sync, carried as C1 on channel 0
//   video_de      : data enable
//   tmds_ch0/1/2  : blue / green / red symbols
//   tmds_clk_word : constant clock-channel pattern
module tmds_word_encoder
  import tmds_word_encoder_pkg::*;
(
  input  logic             pclk,
  input  logic             reset_n,
  input  logic [23:0]      video_din,
  input  logic             video_hsync,
  input  logic             video_vsync,
  input  logic             video_de,
  output logic [SYM_W-1:0] tmds_ch0,
  output logic [SYM_W-1:0] tmds_ch1,
  output logic [SYM_W-1:0] tmds_ch2,
  output logic [SYM_W-1:0] tmds_clk_word
);

  tmds_channel_encoder u_ch0 (
    .pclk    (pclk),
    .reset_n (reset_n),
    .data    (video_din[7:0]),
    .c0      (video_hsync),
    .c1      (video_vsync),
    .de      (video_de),
    .symbol  (tmds_ch0)
  );

  tmds_channel_encoder u_ch1 (
    .pclk    (pclk),
    .reset_n (reset_n),
    .data    (video_din[15:8]),
    .c0      (1'b0),
    .c1      (1'b0),
    .de      (video_de),
    .symbol  (tmds_ch1)
  );

  tmds_channel_encoder u_ch2 (
    .pclk    (pclk),
    .reset_n (reset_n),
    .data    (video_din[23:16]),
    .c0      (1'b0),
    .c1      (1'b0),
    .de      (video_de),
    .symbol  (tmds_ch2)
  );

  assign tmds_clk_word = CLK_WORD;

endmodule

// File: tb/tb_tmds_word_encoder.sv
// Self-checking bench for tmds_word_encoder: the driver pushes the
// reference model's expected symbols into a queue each cycle and a
// separate monitor pops and compares them two edges later.
module tb_tmds_word_encoder;

  typedef struct {
    bit         chk;
    bit         de;
    logic [9:0] s0;
    logic [9:0] s1;
    logic [9:0] s2;
  } exp_t;

  logic        pclk;
  logic        reset_n;
  logic [23:0] video_din;
  logic        video_hsync;
  logic        video_vsync;
  logic        video_de;
  logic [9:0]  tmds_ch0;
  logic [9:0]  tmds_ch1;
  logic [9:0]  tmds_ch2;
  logic [9:0]  tmds_clk_word;

  int   checks;
  int   errors;
  exp_t exp_q[$];
  int   cnt_m[3];

  exp_t mon_cur;
  exp_t mon_prev;
  bit   mon_have_cur;
  bit   mon_have_prev;
  int   disp[3];

  tmds_word_encoder dut (
    .pclk          (pclk),
    .reset_n       (reset_n),
    .video_din     (video_din),
    .video_hsync   (video_hsync),
    .video_vsync   (video_vsync),
    .video_de      (video_de),
    .tmds_ch0      (tmds_ch0),
    .tmds_ch1      (tmds_ch1),
    .tmds_ch2      (tmds_ch2),
    .tmds_clk_word (tmds_clk_word)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  function automatic int ones(logic [9:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) if (v[i]) n++;
    return n;
  endfunction

  // Reference encoder written directly from the DVI rules with integers.
  function automatic logic [9:0] model_sym(int ch, bit de, bit [1:0] c, logic [7:0] d);
    int         n1;
    int         n0;
    bit         xn;
    bit         q8;
    logic [7:0] qm;
    logic [9:0] s;
    if (!de) begin
      cnt_m[ch] = 0;
      case (c)
        2'd0:    return 10'b1101010100;
        2'd1:    return 10'b0010101011;
        2'd2:    return 10'b0101010100;
        default: return 10'b1010101011;
      endcase
    end
    n1 = ones({2'b00, d});
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = xn ? (qm[i-1] == d[i]) : (qm[i-1] != d[i]);
    end
    q8 = !xn;
    n1 = ones({2'b00, qm});
    n0 = 8 - n1;
    if (cnt_m[ch] == 0 || n1 == n0) begin
      s = {~q8, q8, q8 ? qm : ~qm};
      cnt_m[ch] += q8 ? (n1 - n0) : (n0 - n1);
    end else if ((cnt_m[ch] > 0 && n1 > n0) || (cnt_m[ch] < 0 && n0 > n1)) begin
      s = {1'b1, q8, ~qm};
      cnt_m[ch] += 2 * int'(q8) + (n0 - n1);
    end else begin
      s = {1'b0, q8, qm};
      cnt_m[ch] += (n1 - n0) - 2 * int'(!q8);
    end
    return s;
  endfunction

  task automatic checkOutput(string name, logic [9:0] got, logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  // Drive one pixel on the falling edge and queue the model's prediction.
  task automatic applyStimulus(bit de, bit hs, bit vs, logic [23:0] din);
    exp_t e;
    @(negedge pclk);
    video_de    = de;
    video_hsync = hs;
    video_vsync = vs;
    video_din   = din;
    e.chk = reset_n;
    e.de  = de;
    if (reset_n) begin
      e.s0 = model_sym(0, de, {vs, hs}, din[7:0]);
      e.s1 = model_sym(1, de, 2'b00, din[15:8]);
      e.s2 = model_sym(2, de, 2'b00, din[23:16]);
    end else begin
      cnt_m = '{0, 0, 0};
      e.s0  = '0;
      e.s1  = '0;
      e.s2  = '0;
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [23:0] rand_pixel();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 24'h000000;
    if (r == 1) return 24'hFFFFFF;
    return 24'($urandom());
  endfunction

  // Monitor: the item sampled on one rising edge is on the outputs just
  // after the next rising edge. Also tracks running disparity per channel.
  initial begin
    mon_have_cur = 1'b0;
    disp = '{0, 0, 0};
    forever begin
      @(posedge pclk);
      mon_have_prev = mon_have_cur;
      mon_prev      = mon_cur;
      if (exp_q.size() > 0) begin
        mon_cur      = exp_q.pop_front();
        mon_have_cur = 1'b1;
      end else begin
        mon_have_cur = 1'b0;
      end
      #1;
      if (!reset_n) begin
        disp = '{0, 0, 0};
      end else if (mon_have_prev && mon_prev.chk) begin
        checkOutput("sb_ch0", tmds_ch0, mon_prev.s0);
        checkOutput("sb_ch1", tmds_ch1, mon_prev.s1);
        checkOutput("sb_ch2", tmds_ch2, mon_prev.s2);
        if (!mon_prev.de) begin
          disp = '{0, 0, 0};
        end else begin
          disp[0] += 2 * ones(tmds_ch0) - 10;
          disp[1] += 2 * ones(tmds_ch1) - 10;
          disp[2] += 2 * ones(tmds_ch2) - 10;
          for (int ch = 0; ch < 3; ch++) begin
            checks++;
            if (disp[ch] > 10 || disp[ch] < -10) begin
              errors++;
              $display("[TB] FAIL disparity_ch%0d: got %0d want within +/-10 at %0t",
                       ch, disp[ch], $time);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [9:0] tok;
    bit         hs;
    bit         vs;
    bit         aborted;
    checks      = 0;
    errors      = 0;
    cnt_m       = '{0, 0, 0};
    reset_n     = 1'b0;
    video_din   = '0;
    video_hsync = 1'b0;
    video_vsync = 1'b0;
    video_de    = 1'b0;

    // Reset held: control token 00 everywhere plus the clock word.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("rst_ch0", tmds_ch0, 10'b1101010100);
    checkOutput("rst_ch1", tmds_ch1, 10'b1101010100);
    checkOutput("rst_ch2", tmds_ch2, 10'b1101010100);
    checkOutput("rst_clk", tmds_clk_word, 10'b1111100000);

    reset_n = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("idle_ch0", tmds_ch0, 10'b1101010100);
    checkOutput("idle_clk", tmds_clk_word, 10'b1111100000);

    // All four sync combinations on channel 0.
    for (int k = 0; k < 4; k++) begin
      hs = k[0];
      vs = k[1];
      case (k)
        0:       tok = 10'b1101010100;
        1:       tok = 10'b0010101011;
        2:       tok = 10'b0101010100;
        default: tok = 10'b1010101011;
      endcase
      repeat (3) applyStimulus(1'b0, hs, vs, 24'h0);
      checkOutput("tok_ch0", tmds_ch0, tok);
      checkOutput("tok_ch1", tmds_ch1, 10'b1101010100);
      checkOutput("tok_ch2", tmds_ch2, 10'b1101010100);
    end

    // Two zero pixels from a balanced start.
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000);
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h000000);
    checkOutput("de_latency_ch0", tmds_ch0, 10'b1101010100);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("zero1_ch0", tmds_ch0, 10'b0100000000);
    checkOutput("zero1_ch2", tmds_ch2, 10'b0100000000);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("zero2_ch0", tmds_ch0, 10'b1111111111);
    checkOutput("zero2_ch2", tmds_ch2, 10'b1111111111);

    // Full-scale green from a balanced start.
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h00FF00);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    checkOutput("green_ch1", tmds_ch1, 10'b1000000000);
    checkOutput("green_ch0", tmds_ch0, 10'b0100000000);

    // Random lines with blanking; line 2 is cut short by a reset.
    for (int line = 0; line < 4; line++) begin
      hs = 1'($urandom());
      vs = 1'($urandom());
      for (int b = 0; b < 40; b++) begin
        applyStimulus(1'b0, 1'($urandom()), 1'($urandom()), 24'($urandom()));
      end
      aborted = 1'b0;
      for (int px = 0; px < 1920 && !aborted; px++) begin
        applyStimulus(1'b1, hs, vs, rand_pixel());
        if (line == 2 && px == 700) begin
          #2 reset_n = 1'b0;
          #1;
          checkOutput("async_rst_ch0", tmds_ch0, 10'b1101010100);
          checkOutput("async_rst_ch1", tmds_ch1, 10'b1101010100);
          checkOutput("async_rst_ch2", tmds_ch2, 10'b1101010100);
          cnt_m = '{0, 0, 0};
          repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
          reset_n = 1'b1;
          aborted = 1'b1;
        end
      end
    end

    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    @(posedge pclk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d queued want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
